// File: rtl/branch_fetch_unit.sv
// Fetch-stage PC unit: owns the PC, drives the instruction-memory request
// handshake, fills IF/ID, and handles stall, branch redirect/flush and discard.
module branch_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [63:0] PC_STEP  = 64'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] offset_sh,
  input  logic [63:0] br_pc,
  input  logic        br_taken,
  input  logic        stall,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        ifid_valid,
  output logic [63:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [63:0] pc_out
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [63:0] pc_reg, pc_next;
  logic [63:0] fetch_addr_reg, fetch_addr_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [63:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_instr_reg, ifid_instr_next;
  logic [63:0] skid_pc_reg, skid_pc_next;
  logic [31:0] skid_instr_reg, skid_instr_next;

  logic [63:0] target;
  logic [63:0] seq_pc;

  assign target = br_pc + offset_sh;
  assign seq_pc = fetch_addr_reg + PC_STEP;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    fetch_addr_next = fetch_addr_reg;
    ifid_valid_next = ifid_valid_reg;
    ifid_pc_next    = ifid_pc_reg;
    ifid_instr_next = ifid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    skid_instr_next = skid_instr_reg;

    case (state_reg)
      BOOT: begin
        state_next = FETCH;
        if (br_taken) begin
          pc_next         = target;
          fetch_addr_next = target;
          ifid_valid_next = 1'b0;
        end else begin
          fetch_addr_next = pc_reg;
        end
      end

      FETCH: begin
        if (br_taken) begin
          pc_next         = target;
          ifid_valid_next = 1'b0;
          if (imem_ack) begin
            fetch_addr_next = target;
          end else begin
            state_next = DISCARD;
          end
        end else if (imem_ack) begin
          pc_next = seq_pc;
          if (stall) begin
            skid_pc_next    = fetch_addr_reg;
            skid_instr_next = imem_rdata;
            state_next      = HOLD;
          end else begin
            ifid_valid_next = 1'b1;
            ifid_pc_next    = fetch_addr_reg;
            ifid_instr_next = imem_rdata;
            fetch_addr_next = seq_pc;
          end
        end
      end

      HOLD: begin
        if (br_taken) begin
          pc_next         = target;
          fetch_addr_next = target;
          ifid_valid_next = 1'b0;
          state_next      = FETCH;
        end else if (!stall) begin
          ifid_valid_next = 1'b1;
          ifid_pc_next    = skid_pc_reg;
          ifid_instr_next = skid_instr_reg;
          fetch_addr_next = pc_reg;
          state_next      = FETCH;
        end
      end

      DISCARD: begin
        // A redirect arriving together with the stale ack retires the stale
        // request and goes straight to the newest target, like FETCH does.
        if (br_taken) begin
          pc_next         = target;
          ifid_valid_next = 1'b0;
          if (imem_ack) begin
            fetch_addr_next = target;
            state_next      = FETCH;
          end
        end else if (imem_ack) begin
          fetch_addr_next = pc_reg;
          state_next      = FETCH;
        end
      end

      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= BOOT;
      pc_reg         <= RESET_PC;
      fetch_addr_reg <= RESET_PC;
      ifid_valid_reg <= 1'b0;
      ifid_pc_reg    <= 64'd0;
      ifid_instr_reg <= 32'd0;
      skid_pc_reg    <= 64'd0;
      skid_instr_reg <= 32'd0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      fetch_addr_reg <= fetch_addr_next;
      ifid_valid_reg <= ifid_valid_next;
      ifid_pc_reg    <= ifid_pc_next;
      ifid_instr_reg <= ifid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      skid_instr_reg <= skid_instr_next;
    end
  end

  assign imem_req   = (state_reg == FETCH) || (state_reg == DISCARD);
  assign imem_addr  = fetch_addr_reg;
  assign ifid_valid = ifid_valid_reg;
  assign ifid_pc    = ifid_pc_reg;
  assign ifid_instr = ifid_instr_reg;
  assign pc_out     = pc_reg;

endmodule

// File: tb/tb_branch_fetch_unit.sv
// Bench for branch_fetch_unit: directed scenarios then random traffic, all
// compared against a transaction-level model of the fetch unit.
module tb_branch_fetch_unit;
  localparam logic [63:0] RPC = 64'h1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] offset_sh = '0, br_pc = '0;
  logic        br_taken = 1'b0, stall = 1'b0, imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, ifid_valid;
  logic [63:0] imem_addr, ifid_pc, pc_out;
  logic [31:0] ifid_instr;

  int tests = 0;
  int fails = 0;

  branch_fetch_unit #(.RESET_PC(RPC), .PC_STEP(64'd4)) dut (
    .clk(clk), .reset(reset), .offset_sh(offset_sh), .br_pc(br_pc),
    .br_taken(br_taken), .stall(stall), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
    .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  // Model: a request is "open" unless booting or parked in the skid; an open
  // request may be marked stale (drop) after a redirect.
  bit          m_boot, m_parked, m_drop;
  logic [63:0] m_pc, m_addr, m_ipc, s_pc;
  logic        m_v;
  logic [31:0] m_ins, s_ins;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_boot = 1; m_parked = 0; m_drop = 0;
    m_pc = RPC; m_addr = RPC; m_v = 0; m_ipc = 0; m_ins = 0; s_pc = 0; s_ins = 0;
  endtask

  task automatic check_outputs(input string ph);
    check({ph, ".imem_req"}, {63'd0, imem_req}, {63'd0, !m_boot && !m_parked});
    check({ph, ".imem_addr"}, imem_addr, m_addr);
    check({ph, ".pc_out"}, pc_out, m_pc);
    check({ph, ".ifid_valid"}, {63'd0, ifid_valid}, {63'd0, m_v});
    check({ph, ".ifid_pc"}, ifid_pc, m_ipc);
    check({ph, ".ifid_instr"}, {32'd0, ifid_instr}, {32'd0, m_ins});
  endtask

  // One clock: drive inputs, check current outputs, advance the model.
  task automatic cycle(input string ph, input bit br, input bit st, input bit ack_in,
                       input logic [63:0] bpc, input logic [63:0] off);
    bit          ack;
    logic [31:0] rd;
    logic [63:0] tgt;
    ack = ack_in && !m_boot && !m_parked;
    rd  = $urandom;
    tgt = bpc + off;
    br_taken = br; stall = st; imem_ack = ack; imem_rdata = rd;
    br_pc = bpc; offset_sh = off;
    #1 check_outputs(ph);
    if (m_boot) begin
      m_boot = 0;
      if (br) begin m_pc = tgt; m_v = 0; end
      m_addr = m_pc;
    end else if (m_parked) begin
      if (br) begin
        m_pc = tgt; m_v = 0; m_parked = 0; m_addr = tgt;
      end else if (!st) begin
        m_v = 1; m_ipc = s_pc; m_ins = s_ins; m_parked = 0; m_addr = m_pc;
        $display("[TB] %s ifid <= pc=%h instr=%h (from skid)", ph, s_pc, s_ins);
      end
    end else if (br) begin
      m_pc = tgt; m_v = 0;
      if (ack) begin m_addr = tgt; m_drop = 0; end
      else m_drop = 1;
    end else if (ack) begin
      if (m_drop) begin
        m_drop = 0; m_addr = m_pc;
      end else if (!st) begin
        m_v = 1; m_ipc = m_addr; m_ins = rd; m_pc = m_addr + 64'd4; m_addr = m_pc;
        $display("[TB] %s ifid <= pc=%h instr=%h", ph, m_ipc, rd);
      end else begin
        s_pc = m_addr; s_ins = rd; m_pc = m_addr + 64'd4; m_parked = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset(input string ph);
    reset = 1'b1;
    #1;
    check({ph, ".rst_req"}, {63'd0, imem_req}, 64'd0);
    check({ph, ".rst_valid"}, {63'd0, ifid_valid}, 64'd0);
    check({ph, ".rst_ifid_pc"}, ifid_pc, 64'd0);
    check({ph, ".rst_instr"}, {32'd0, ifid_instr}, 64'd0);
    check({ph, ".rst_pc"}, pc_out, RPC);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("p1");
    // 1: zero-wait memory, one instruction per cycle
    cycle("p1", 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle("p1", 0, 0, 1, 0, 0);
    #1 check("p1.ifid_pc_seq", ifid_pc, 64'h1008);
    // 2: three-cycle latency
    for (int i = 0; i < 3; i++) cycle("p2", 0, 0, 0, 0, 0);
    cycle("p2", 0, 0, 1, 0, 0);
    // 3: stall on ack, hold 2 cycles, release
    cycle("p3", 0, 1, 1, 0, 0);
    cycle("p3", 0, 1, 0, 0, 0);
    cycle("p3", 0, 0, 0, 0, 0);
    cycle("p3", 0, 0, 1, 0, 0);
    cycle("p3", 0, 0, 1, 0, 0);
    // 4: redirect with fetch outstanding, target wraps below br_pc
    cycle("p4", 1, 0, 0, 64'h2000, 64'hFFFF_FFFF_FFFF_FFF0);
    cycle("p4", 0, 0, 1, 0, 0);
    #1 check("p4.new_addr", imem_addr, 64'h1FF0);
    cycle("p4", 0, 0, 1, 0, 0);
    #1 check("p4.ifid_pc", ifid_pc, 64'h1FF0);
    // 5: two redirects while discarding; flush under stall
    cycle("p5", 1, 0, 0, 64'h3000, 64'd0);
    cycle("p5", 1, 0, 0, 64'h4000, 64'd0);
    cycle("p5", 0, 0, 1, 0, 0);
    cycle("p5", 0, 0, 1, 0, 0);
    #1 check("p5.ifid_pc", ifid_pc, 64'h4000);
    cycle("p5", 1, 1, 1, 64'h5000, 64'd8);
    #1 check("p5.flush_stall", {63'd0, ifid_valid}, 64'd0);
    // 6: reset mid-HOLD and mid-DISCARD, then PC wrap
    cycle("p6", 0, 1, 1, 0, 0);
    do_reset("p6h");
    cycle("p6", 0, 0, 0, 0, 0);
    cycle("p6", 1, 0, 0, 64'h7000, 64'd0);
    do_reset("p6d");
    cycle("p6", 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0, 64'hC);
    cycle("p6", 0, 0, 1, 0, 0);
    #1 check("p6.wrap_addr", imem_addr, 64'd0);
    cycle("p6", 0, 0, 1, 0, 0);
    #1 check("p6.wrap_ifid", ifid_pc, 64'd0);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset("rnd");
      else cycle("rnd", $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) < 6, {$urandom, $urandom}, {$urandom, $urandom});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
